// File: rtl/reg_pkg.sv
// Shared definitions for the PISO serializer: state encoding and the
// bit-counter width helper.
package reg_pkg;

    // State encoding
    localparam logic [1:0] ST_REPOSO   = 2'b00;
    localparam logic [1:0] ST_DESPLAZA = 2'b01;
    localparam logic [1:0] ST_PARIDAD  = 2'b10;

    typedef enum logic [1:0] {
        REPOSO   = ST_REPOSO,
        DESPLAZA = ST_DESPLAZA,
        PARIDAD  = ST_PARIDAD
    } estado_t;

    // Counter width for an n-bit word; a 1-bit word still needs a 1-bit counter
    function automatic int calc_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_piso_serializador_contador_bits.sv
// Bit-position counter for the serializer: synchronous clear has priority
// over enable; asynchronous active-low reset.
module contador_bits #(
    parameter int CW = 2
) (
    input  logic          reloj,
    input  logic          reset_despeje,
    input  logic          limpiar_i,
    input  logic          habilitar_i,
    output logic [CW-1:0] cuenta
);

    logic [CW-1:0] cuenta_d;
    logic [CW-1:0] cuenta_q;

    // Next count: clear wins, otherwise step when enabled
    always_comb begin
        cuenta_d = cuenta_q;
        if (limpiar_i)
            cuenta_d = '0;
        else if (habilitar_i)
            cuenta_d = cuenta_q + CW'(1);
    end

    // Count register
    always_ff @(posedge reloj or negedge reset_despeje) begin
        if (!reset_despeje)
            cuenta_q <= '0;
        else
            cuenta_q <= cuenta_d;
    end

    assign cuenta = cuenta_q;

endmodule

// File: rtl/reg_piso_serializador.sv
// Parallel-in / serial-out transmitter, MSB first, valid/ready on the
// parallel side. Outputs are decoded from registered state only.
// Optional macro REG_PISO_PARIDAD_EN appends an even-parity bit to each
// word (N+1 cycles per word instead of N).
module reg_piso_serializador
    import reg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         reloj,
    input  logic         reset_despeje,
    input  logic [N-1:0] In,
    input  logic         cargar,
    output logic         listo,
    output logic         Sout,
    output logic         Sout_valido,
    output logic         fin
);

    localparam int            CW     = calc_cw(N);
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    estado_t       estado_q;
    logic [N-1:0]  desp_q;
    logic [CW-1:0] cuenta;
    logic          ultimo_bit;
    logic          acepta;
    logic          cnt_limpiar;
    logic          cnt_habilitar;
`ifdef REG_PISO_PARIDAD_EN
    logic          paridad_q;
`endif

    // Last data bit of the word is on the wire this cycle
    assign ultimo_bit = (estado_q == DESPLAZA) && (cuenta == ULTIMO);

`ifdef REG_PISO_PARIDAD_EN
    assign fin = (estado_q == PARIDAD);
`else
    assign fin = ultimo_bit;
`endif

    // Ready while idle or on the final cycle of a word, so words can abut
    assign listo  = (estado_q == REPOSO) || fin;
    assign acepta = cargar && listo;

    // Serial outputs decoded from state
    always_comb begin
        Sout        = 1'b0;
        Sout_valido = 1'b0;
        case (estado_q)
            DESPLAZA: begin
                Sout        = desp_q[N-1];
                Sout_valido = 1'b1;
            end
`ifdef REG_PISO_PARIDAD_EN
            PARIDAD: begin
                Sout        = paridad_q;
                Sout_valido = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Counter restarts on every accepted word and holds at the last bit
    assign cnt_limpiar   = acepta;
    assign cnt_habilitar = (estado_q == DESPLAZA) && !ultimo_bit;

    contador_bits #(.CW(CW)) u_contador (
        .reloj         (reloj),
        .reset_despeje (reset_despeje),
        .limpiar_i     (cnt_limpiar),
        .habilitar_i   (cnt_habilitar),
        .cuenta        (cuenta)
    );

    // Control FSM with shift register and parity flop
    always_ff @(posedge reloj or negedge reset_despeje) begin
        if (!reset_despeje) begin
            estado_q  <= REPOSO;
            desp_q    <= '0;
`ifdef REG_PISO_PARIDAD_EN
            paridad_q <= 1'b0;
`endif
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (acepta) begin
                        desp_q    <= In;
`ifdef REG_PISO_PARIDAD_EN
                        paridad_q <= ^In;
`endif
                        estado_q  <= DESPLAZA;
                    end
                end
                DESPLAZA: begin
                    desp_q <= desp_q << 1;
                    if (ultimo_bit) begin
`ifdef REG_PISO_PARIDAD_EN
                        estado_q <= PARIDAD;
`else
                        if (acepta)
                            desp_q <= In;
                        else
                            estado_q <= REPOSO;
`endif
                    end
                end
`ifdef REG_PISO_PARIDAD_EN
                PARIDAD: begin
                    if (acepta) begin
                        desp_q    <= In;
                        paridad_q <= ^In;
                        estado_q  <= DESPLAZA;
                    end else begin
                        estado_q  <= REPOSO;
                    end
                end
`endif
                default: estado_q <= REPOSO;
            endcase
        end
    end

endmodule
